memory_access_sequencer: RTL
============================

# memory_access_sequencer

Sequences every access to the 16-byte program RAM through the memory address register (MAR), and shares that path between the CPU control unit and the front-panel program loader. Each granted request runs a fixed three-phase sequence: load the MAR from its bus, perform the RAM read or write, then acknowledge. `prog_mode` selects the requester. The loader has an auto-incrementing 4-bit pointer for stepping through memory from the switches.

## Interface
Parameters:
- `ADDR_W`, 4: address width (MAR and RAM depth 2^ADDR_W).
- `DATA_W`, 8: RAM data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `prog_mode`  in  1  1 = loader owns memory path, 0 = CPU owns it.
- `cpu_req`  in  1  CPU access request; level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` high.
- `cpu_addr`  in  ADDR_W  CPU target address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to CPU.
- `cpu_rdata`  out  DATA_W  last CPU read result; held until next CPU read completes.
- `ld_req`  in  1  loader request; single-cycle pulse (debounced button).
- `ld_we`  in  1  loader write enable, sampled with `ld_req`.
- `ld_auto`  in  1  1 = use internal pointer, 0 = use `ld_addr`; sampled with `ld_req`.
- `ld_set`  in  1  pulse: `ld_ptr <= ld_addr`.
- `ld_addr`  in  ADDR_W  loader switch address.
- `ld_wdata`  in  DATA_W  loader switch data, sampled with `ld_req`.
- `ld_ack`  out  1  one-cycle completion pulse to loader.
- `ld_rdata`  out  DATA_W  last loader read result.
- `ld_ptr`  out  ADDR_W  auto-increment pointer.
- `mar_bus`  out  ADDR_W  address driven to MAR bus input.
- `mar_read_from_bus`  out  1  MAR load strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM asynchronous read data at current MAR address.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADDR, ACCESS, ACK. Registered state; outputs decoded from state plus latched request (owner, we, addr, wdata).
- IDLE with `prog_mode`=0 and `cpu_req`=1: latch the CPU request, then go to ADDR.
- IDLE with `prog_mode`=1 and `ld_pending`=1: latch the loader request, clear `ld_pending`, then go to ADDR. Otherwise stay in IDLE.
- `ld_pending` is set by `ld_req`. A `ld_req` while pending, or while the loader is in service, is dropped. `ld_pending` clears when `prog_mode`=0. The request fields are captured into a pending buffer on `ld_req`.
- ADDR: `mar_bus`=latched address, `mar_read_from_bus`=1. Next state is ACCESS.
- ACCESS: if write, `ram_we`=1 and `ram_wdata`=latched data. If read, capture `ram_rdata` into the owner's rdata at the clock edge. Next state is ACK.
- ACK: pulse the owner's ack. If the owner is the loader and the request was auto, `ld_ptr` increments, wrapping 15 to 0. Next state is IDLE.
- `ld_set` and an auto increment in the same cycle: `ld_set` wins.
- `prog_mode` toggling mid-sequence does not abort; the current owner completes.
- Outside the sequence, `mar_bus`, `mar_read_from_bus`, `ram_we` and `ram_wdata` are 0.

## Timing
- Request sampled in IDLE at edge E0. ADDR runs in cycle 1, ACCESS in cycle 2, ACK in cycle 3, back to IDLE in cycle 4. Request-to-ack latency is 3 cycles. Peak throughput is one access per 4 cycles.
- The MAR holds the new address from the start of ACCESS, so `ram_rdata` is valid for the whole ACCESS cycle.
- `cpu_req` still high in the cycle after ACK starts a new access. The CPU must drop `cpu_req` in the ACK cycle for a single access.
- `cpu_req` falling during ADDR or ACCESS is ignored; the access completes.
- Reset (`rst`=0), asynchronous, any state:
  - State goes to IDLE.
  - `ld_pending`, `ld_ptr`, `cpu_rdata`, `ld_rdata`, `cpu_ack`, `ld_ack`, `busy`, `ram_we`, `mar_read_from_bus`, `mar_bus` and `ram_wdata` go to 0.
  - `ram_we` drops immediately, not at the next edge.

## Test plan
- CPU write then read: `prog_mode`=0; write 0xA5 to addr 0x3, then read addr 0x3.
  - `mar_read_from_bus` high in cycle 1.
  - `ram_we` high for exactly cycle 2.
  - `cpu_ack` in cycle 3.
  - `cpu_rdata`=0xA5 after the read.
- Loader auto-fill: `prog_mode`=1, `ld_set` with `ld_addr`=0xE, then three auto writes of 0x11, 0x22, 0x33.
  - RAM[E]=0x11, RAM[F]=0x22, RAM[0]=0x33.
  - `ld_ptr`=0x1 (wrap).
- Mode gating: `prog_mode`=0, `ld_req` pulse, then `cpu_req` at addr 0x5.
  - No loader access.
  - `ld_pending` cleared.
  - CPU served at 0x5.
  - `ld_ack` never asserts.
- Mid-transaction mode change: CPU read in flight; `prog_mode` goes to 1 in the ADDR cycle while `ld_req` pulses.
  - `cpu_ack` in cycle 3.
  - Loader served starting cycle 4.
  - Loader ack in cycle 7.
- Dropped pulse: two `ld_req` pulses 1 cycle apart with `prog_mode`=1.
  - Exactly one access.
  - One `ld_ack`.
- Reset during ACCESS of a write: `rst` low mid-cycle 2.
  - `ram_we` drops immediately.
  - `busy`=0, `ld_ptr`=0.
  - No ack is ever issued for that request.

Source files
------------

// File: rtl/memory_access_sequencer.sv
// memory_access_sequencer
//   Arbitrates the single MAR/RAM path between the CPU control unit and the
//   front-panel program loader. Each granted request runs a fixed sequence:
//   ADDR (load MAR) -> ACCESS (RAM read/write) -> ACK (one-cycle pulse).
//   prog_mode picks which requester may be granted from IDLE.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   prog_mode           : 1 = loader owns the path, 0 = CPU owns it
//   cpu_req/we/addr/wdata, cpu_ack, cpu_rdata : CPU request/response
//   ld_req/we/auto/set/addr/wdata, ld_ack, ld_rdata, ld_ptr : loader side
//   mar_bus, mar_read_from_bus : MAR load path
//   ram_we, ram_wdata, ram_rdata : RAM strobe/data (read is asynchronous)
//   busy                : high whenever the sequencer is not IDLE
//
// All outputs are registered. They are computed from the next state and the
// next latched request, so they line up with the state they belong to while
// still coming straight out of flops (reset clears them asynchronously).

module memory_access_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_auto,
  input  logic              ld_set,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ld_ptr,
  output logic [ADDR_W-1:0] mar_bus,
  output logic              mar_read_from_bus,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              state_r, state_next_s;

  // Latched request currently in service
  logic                own_ld_r, own_ld_next_s;
  logic                we_r, we_next_s;
  logic                auto_r, auto_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [DATA_W-1:0]   wdata_r, wdata_next_s;

  // Loader pending buffer (captured on an accepted ld_req pulse)
  logic                ld_pending_r;
  logic                pend_we_r, pend_auto_r;
  logic [ADDR_W-1:0]   pend_addr_r;
  logic [DATA_W-1:0]   pend_wdata_r;

  logic                grant_cpu_s, grant_ld_s, ld_accept_s, ld_in_service_s;

  // Registered outputs
  logic                cpu_ack_r, ld_ack_r, busy_r, ram_we_r, mar_rd_r;
  logic [ADDR_W-1:0]   mar_bus_r, ld_ptr_r;
  logic [DATA_W-1:0]   ram_wdata_r, cpu_rdata_r, ld_rdata_r;

  // A loader pulse is dropped while one is already pending or being served
  assign ld_in_service_s = (state_r != S_IDLE) && own_ld_r;
  assign ld_accept_s     = ld_req && !ld_pending_r && !ld_in_service_s;

  // Next-state decode, grant selection and next latched-request values
  always_comb begin
    state_next_s  = state_r;
    grant_cpu_s   = 1'b0;
    grant_ld_s    = 1'b0;
    own_ld_next_s = own_ld_r;
    we_next_s     = we_r;
    auto_next_s   = auto_r;
    addr_next_s   = addr_r;
    wdata_next_s  = wdata_r;
    case (state_r)
      S_IDLE: begin
        if (!prog_mode && cpu_req) begin
          grant_cpu_s  = 1'b1;
          state_next_s = S_ADDR;
        end else if (prog_mode && ld_pending_r) begin
          grant_ld_s   = 1'b1;
          state_next_s = S_ADDR;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ADDR:   state_next_s = S_ACCESS;
      S_ACCESS: state_next_s = S_ACK;
      S_ACK:    state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
    if (grant_cpu_s) begin
      own_ld_next_s = 1'b0;
      we_next_s     = cpu_we;
      auto_next_s   = 1'b0;
      addr_next_s   = cpu_addr;
      wdata_next_s  = cpu_wdata;
    end else if (grant_ld_s) begin
      // Auto requests resolve the pointer at grant time, after any ld_set
      own_ld_next_s = 1'b1;
      we_next_s     = pend_we_r;
      auto_next_s   = pend_auto_r;
      addr_next_s   = pend_auto_r ? ld_ptr_r : pend_addr_r;
      wdata_next_s  = pend_wdata_r;
    end else begin
      own_ld_next_s = own_ld_r;
    end
  end

  // State, latched request and registered bus/strobe outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      own_ld_r    <= 1'b0;
      we_r        <= 1'b0;
      auto_r      <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      mar_rd_r    <= 1'b0;
      mar_bus_r   <= {ADDR_W{1'b0}};
      ram_we_r    <= 1'b0;
      ram_wdata_r <= {DATA_W{1'b0}};
      cpu_ack_r   <= 1'b0;
      ld_ack_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      own_ld_r    <= own_ld_next_s;
      we_r        <= we_next_s;
      auto_r      <= auto_next_s;
      addr_r      <= addr_next_s;
      wdata_r     <= wdata_next_s;
      busy_r      <= (state_next_s != S_IDLE);
      mar_rd_r    <= (state_next_s == S_ADDR);
      mar_bus_r   <= (state_next_s == S_ADDR) ? addr_next_s : {ADDR_W{1'b0}};
      ram_we_r    <= (state_next_s == S_ACCESS) && we_next_s;
      ram_wdata_r <= ((state_next_s == S_ACCESS) && we_next_s) ? wdata_next_s
                                                                : {DATA_W{1'b0}};
      cpu_ack_r   <= (state_next_s == S_ACK) && !own_ld_next_s;
      ld_ack_r    <= (state_next_s == S_ACK) && own_ld_next_s;
    end
  end

  // Loader pending flag and request buffer; leaving prog mode flushes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_pending_r <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_auto_r  <= 1'b0;
      pend_addr_r  <= {ADDR_W{1'b0}};
      pend_wdata_r <= {DATA_W{1'b0}};
    end else if (!prog_mode || grant_ld_s) begin
      ld_pending_r <= 1'b0;
    end else if (ld_accept_s) begin
      ld_pending_r <= 1'b1;
      pend_we_r    <= ld_we;
      pend_auto_r  <= ld_auto;
      pend_addr_r  <= ld_addr;
      pend_wdata_r <= ld_wdata;
    end else begin
      ld_pending_r <= ld_pending_r;
    end
  end

  // Read capture at the end of ACCESS into the owner's result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_r <= {DATA_W{1'b0}};
      ld_rdata_r  <= {DATA_W{1'b0}};
    end else if ((state_r == S_ACCESS) && !we_r) begin
      if (own_ld_r) begin
        ld_rdata_r <= ram_rdata;
      end else begin
        cpu_rdata_r <= ram_rdata;
      end
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
    end
  end

  // Loader pointer: ld_set overrides the post-ACK auto increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ptr_r <= {ADDR_W{1'b0}};
    end else if (ld_set) begin
      ld_ptr_r <= ld_addr;
    end else if ((state_r == S_ACK) && own_ld_r && auto_r) begin
      ld_ptr_r <= ld_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      ld_ptr_r <= ld_ptr_r;
    end
  end

  assign cpu_ack           = cpu_ack_r;
  assign ld_ack            = ld_ack_r;
  assign cpu_rdata         = cpu_rdata_r;
  assign ld_rdata          = ld_rdata_r;
  assign ld_ptr            = ld_ptr_r;
  assign mar_bus           = mar_bus_r;
  assign mar_read_from_bus = mar_rd_r;
  assign ram_we            = ram_we_r;
  assign ram_wdata         = ram_wdata_r;
  assign busy              = busy_r;

endmodule
